// File: rtl/dyn_bank_allocator_pkg.sv
// Shared state encodings and sizing helper for the dynamic bank allocator.
package dyn_bank_allocator_pkg;

    localparam logic [1:0] ST_ENABLE = 2'b01;
    localparam logic [1:0] ST_DRAIN  = 2'b10;
    localparam logic [1:0] ST_SWITCH = 2'b11;

    // Bits needed to hold values 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dyn_bank_rr_select.sv
// Combinational round-robin picker: first request at or after the one-hot
// pointer, wrapping around, returned one-hot with an any-valid flag.
module dyn_bank_rr_select #(
    parameter int width = 5
) (
    input  logic [width-1:0] req_i,
    input  logic [width-1:0] ptr_i,
    output logic [width-1:0] gnt_o,
    output logic             valid_o
);

    always_comb begin
        logic found;
        found   = 1'b0;
        gnt_o   = '0;
        for (int j = 0; j < width; j++) begin
            if (ptr_i[j]) begin
                for (int k = 0; k < width; k++) begin
                    if (!found && req_i[(j + k) % width]) begin
                        gnt_o[(j + k) % width] = 1'b1;
                        found                  = 1'b1;
                    end
                end
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/dyn_bank_allocator.sv
// Per-bank ownership controller: hysteretic pressure tracking, round-robin
// owner selection, drain-then-switch hand-over. Option: DYN_BANK_DRAIN_TIMEOUT_EN.
//
// state  | meaning
// ENABLE | shared VCs allocatable; hold counter runs down; looks for a new owner
// DRAIN  | allocation blocked; waits for bank shared VCs to free and empty
// SWITCH | one cycle; grant takes the latched target, hold reloads
module dyn_bank_allocator
    import dyn_bank_allocator_pkg::*;
#(
    parameter int num_ports        = 5,
    parameter int num_vcs          = 8,
    parameter int num_vcs_per_bank = 2,
    parameter int bank_id          = 0,
    parameter int counter_width    = 4,
    parameter int congest_thresh   = 15,
    parameter int release_thresh   = 8,
    parameter int min_hold         = 4,
    parameter int drain_timeout    = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [num_ports*num_vcs-1:0]   allocated_ip_ivc,
    input  logic [num_ports*num_vcs-1:0]   allocated_ip_shared_ivc,
    input  logic [num_vcs_per_bank-1:0]    shared_ivc_empty,
    output logic                           ready_for_allocation,
    output logic [num_ports-1:0]           memory_bank_grant_out,
    output logic                           grant_changed,
    output logic                           drain_aborted
);

    localparam int HOLD_W = cnt_width(min_hold);
    localparam int SLICE  = bank_id * num_vcs_per_bank;

    localparam logic [counter_width-1:0] CNT_MAX = {counter_width{1'b1}};
    localparam logic [counter_width-1:0] CONG    = counter_width'(congest_thresh);
    localparam logic [counter_width-1:0] REL     = counter_width'(release_thresh);
    localparam logic [HOLD_W-1:0]        HOLD_LD = HOLD_W'(min_hold);
    localparam logic [num_ports-1:0]     RST_GRANT =
        {{(num_ports-1){1'b0}}, 1'b1} << (bank_id % num_ports);

    logic [counter_width-1:0] cnt_q [num_ports];
    logic [counter_width-1:0] cnt_d [num_ports];
    logic [num_ports-1:0]     congested_q, congested_d;
    logic [num_ports-1:0]     bank_full;
    logic [1:0]               state_q, state_d;
    logic [num_ports-1:0]     grant_q, grant_d;
    logic [num_ports-1:0]     target_q, target_d;
    logic [HOLD_W-1:0]        hold_q, hold_d;
    logic                     gc_q, gc_d;
    logic                     shared_busy;
    logic                     drain_done;
    logic [num_ports-1:0]     rr_ptr;
    logic [num_ports-1:0]     rr_gnt;
    logic                     rr_valid;

    logic unused_ins;
    assign unused_ins = ^{allocated_ip_ivc, allocated_ip_shared_ivc};

    always_comb begin
        bank_full   = '0;
        shared_busy = 1'b0;
        for (int p = 0; p < num_ports; p++) begin
            bank_full[p] = &allocated_ip_ivc[p*num_vcs + SLICE +: num_vcs_per_bank];
            if (|allocated_ip_shared_ivc[p*num_vcs + SLICE +: num_vcs_per_bank])
                shared_busy = 1'b1;
        end
    end

    assign drain_done = !shared_busy && (&shared_ivc_empty);

    // Saturating pressure counters; congestion flag follows the registered count.
    always_comb begin
        for (int p = 0; p < num_ports; p++) begin
            if (bank_full[p])
                cnt_d[p] = (cnt_q[p] == CNT_MAX) ? cnt_q[p]
                                                 : cnt_q[p] + counter_width'(1);
            else
                cnt_d[p] = (cnt_q[p] == '0) ? cnt_q[p]
                                            : cnt_q[p] - counter_width'(1);
            congested_d[p] = congested_q[p];
            if (cnt_q[p] >= CONG)
                congested_d[p] = 1'b1;
            else if (cnt_q[p] <= REL)
                congested_d[p] = 1'b0;
        end
    end

    // Pointer one past the owner, so the owner is the last candidate.
    assign rr_ptr = {grant_q[num_ports-2:0], grant_q[num_ports-1]};

    dyn_bank_rr_select #(
        .width (num_ports)
    ) u_rr_select (
        .req_i   (congested_q),
        .ptr_i   (rr_ptr),
        .gnt_o   (rr_gnt),
        .valid_o (rr_valid)
    );

`ifdef DYN_BANK_DRAIN_TIMEOUT_EN
    localparam int DRN_W = cnt_width(drain_timeout);
    localparam logic [DRN_W-1:0] DRN_LD = DRN_W'(drain_timeout - 1);

    logic [DRN_W-1:0] drn_q, drn_d;
    logic             abort_q, abort_d;
`else
    logic unused_cfg;
    assign unused_cfg = (drain_timeout > 0);
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        target_d = target_q;
        hold_d   = hold_q;
        gc_d     = 1'b0;
`ifdef DYN_BANK_DRAIN_TIMEOUT_EN
        drn_d    = drn_q;
        abort_d  = 1'b0;
`endif
        case (state_q)
            ST_ENABLE: begin
                if (hold_q != '0)
                    hold_d = hold_q - HOLD_W'(1);
                if (hold_q == '0 && rr_valid && rr_gnt != grant_q) begin
                    state_d  = ST_DRAIN;
                    target_d = rr_gnt;
`ifdef DYN_BANK_DRAIN_TIMEOUT_EN
                    drn_d    = DRN_LD;
`endif
                end
            end
            ST_DRAIN: begin
                if (drain_done)
                    state_d = ST_SWITCH;
`ifdef DYN_BANK_DRAIN_TIMEOUT_EN
                else if (drn_q == '0) begin
                    state_d = ST_ENABLE;
                    hold_d  = HOLD_LD;
                    abort_d = 1'b1;
                end else
                    drn_d = drn_q - DRN_W'(1);
`endif
            end
            ST_SWITCH: begin
                grant_d = target_q;
                hold_d  = HOLD_LD;
                gc_d    = 1'b1;
                state_d = ST_ENABLE;
            end
            default: state_d = ST_ENABLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < num_ports; p++)
                cnt_q[p] <= '0;
            congested_q <= '0;
            state_q     <= ST_ENABLE;
            grant_q     <= RST_GRANT;
            target_q    <= RST_GRANT;
            hold_q      <= '0;
            gc_q        <= 1'b0;
        end else begin
            for (int p = 0; p < num_ports; p++)
                cnt_q[p] <= cnt_d[p];
            congested_q <= congested_d;
            state_q     <= state_d;
            grant_q     <= grant_d;
            target_q    <= target_d;
            hold_q      <= hold_d;
            gc_q        <= gc_d;
        end
    end

`ifdef DYN_BANK_DRAIN_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drn_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            drn_q   <= drn_d;
            abort_q <= abort_d;
        end
    end

    assign drain_aborted = abort_q;
`else
    assign drain_aborted = 1'b0;
`endif

    assign ready_for_allocation  = (state_q == ST_ENABLE);
    assign memory_bank_grant_out = grant_q;
    assign grant_changed         = gc_q;

endmodule

// File: tb/tb_dyn_bank_allocator.sv
// Directed bench for dyn_bank_allocator (bank_id 2): vector table plus
// hand-written reset, drain-timeout and reset-in-SWITCH sequences.
module tb_dyn_bank_allocator;

    localparam int NP   = 5;
    localparam int NV   = 8;
    localparam int NB   = 2;
    localparam int BANK = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP*NV-1:0]  alloc_ivc;
    logic [NP*NV-1:0]  alloc_sh;
    logic [NB-1:0]     empty;
    logic              rdy;
    logic [NP-1:0]     grant;
    logic              gc;
    logic              abort;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dyn_bank_allocator #(
        .num_ports        (NP),
        .num_vcs          (NV),
        .num_vcs_per_bank (NB),
        .bank_id          (BANK),
        .counter_width    (4),
        .congest_thresh   (15),
        .release_thresh   (8),
        .min_hold         (4),
        .drain_timeout    (16)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .allocated_ip_ivc        (alloc_ivc),
        .allocated_ip_shared_ivc (alloc_sh),
        .shared_ivc_empty        (empty),
        .ready_for_allocation    (rdy),
        .memory_bank_grant_out   (grant),
        .grant_changed           (gc),
        .drain_aborted           (abort)
    );

    typedef struct {
        bit         rst;
        logic [4:0] full;
        bit         sh_busy;
        logic [1:0] emp;
        int         reps;
        logic       e_rdy;
        logic [4:0] e_grant;
        logic       e_gc;
        logic       e_abort;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rst, logic [4:0] full, bit sh_busy, logic [1:0] emp,
                                int reps, logic e_rdy, logic [4:0] e_grant, logic e_gc);
        vec_t v;
        v.rst = rst; v.full = full; v.sh_busy = sh_busy; v.emp = emp; v.reps = reps;
        v.e_rdy = e_rdy; v.e_grant = e_grant; v.e_gc = e_gc; v.e_abort = 1'b0;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] full, input bit sh_busy, input logic [1:0] emp);
        alloc_ivc = '0;
        alloc_sh  = '0;
        for (int p = 0; p < NP; p++)
            alloc_ivc[p*NV + BANK*NB +: NB] = {NB{full[p]}};
        if (sh_busy)
            alloc_sh[BANK*NB] = 1'b1;
        empty = emp;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(5'b00000, 1'b0, 2'b11);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Port 0 saturates at E15, congested at E16, DRAIN E17, SWITCH E18, grant E19.
        add(1, 5'b00001, 0, 2'b11, 14, 1, 5'b00100, 0);
        add(0, 5'b00001, 0, 2'b11,  1, 1, 5'b00100, 0);
        add(0, 5'b00001, 0, 2'b11,  1, 1, 5'b00100, 0);
        add(0, 5'b00001, 0, 2'b11,  1, 0, 5'b00100, 0);
        add(0, 5'b00001, 0, 2'b11,  1, 0, 5'b00100, 0);
        add(0, 5'b00001, 0, 2'b11,  1, 1, 5'b00001, 1);
        add(0, 5'b00001, 0, 2'b11,  1, 1, 5'b00001, 0);
        add(0, 5'b00001, 0, 2'b11,  4, 1, 5'b00001, 0);
        // Ports 1 and 3 congested, owner 2: port 3 first, port 1 once the hold expires.
        add(1, 5'b01010, 0, 2'b11, 14, 1, 5'b00100, 0);
        add(0, 5'b01010, 0, 2'b11,  2, 1, 5'b00100, 0);
        add(0, 5'b01010, 0, 2'b11,  1, 0, 5'b00100, 0);
        add(0, 5'b01010, 0, 2'b11,  2, 1, 5'b01000, 1);
        add(0, 5'b00010, 0, 2'b11,  4, 1, 5'b01000, 0);
        add(0, 5'b00010, 0, 2'b11,  1, 0, 5'b01000, 0);
        add(0, 5'b00010, 0, 2'b11,  1, 0, 5'b01000, 0);
        add(0, 5'b00010, 0, 2'b11,  1, 1, 5'b00010, 1);
        // Port 4 congested, shared VC busy for 10 DRAIN cycles, switch 2 cycles after release.
        add(1, 5'b10000, 1, 2'b01, 16, 1, 5'b00100, 0);
        add(0, 5'b10000, 1, 2'b01,  1, 0, 5'b00100, 0);
        add(0, 5'b10000, 1, 2'b01,  9, 0, 5'b00100, 0);
        add(0, 5'b10000, 0, 2'b11,  1, 0, 5'b00100, 0);
        add(0, 5'b10000, 0, 2'b11,  1, 1, 5'b10000, 1);

        reset = 1'b1;
        drive(5'b00000, 1'b0, 2'b11);
        #2;
        chk("reset_grant", grant, 5'b00100);
        chk("reset_rdy",   rdy,   1'b1);
        chk("reset_gc",    gc,    1'b0);
        chk("reset_abort", abort, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst)
                do_reset();
            drive(vecs[i].full, vecs[i].sh_busy, vecs[i].emp);
            step(vecs[i].reps);
            chk($sformatf("vec%0d_rdy", i),   rdy,   vecs[i].e_rdy);
            chk($sformatf("vec%0d_grant", i), grant, vecs[i].e_grant);
            chk($sformatf("vec%0d_gc", i),    gc,    vecs[i].e_gc);
            chk($sformatf("vec%0d_abort", i), abort, vecs[i].e_abort);
        end

        // Shared VC never frees while port 4 wants the bank.
        do_reset();
        drive(5'b10000, 1'b1, 2'b01);
        step(17);
        chk("to_drain_rdy", rdy, 1'b0);
`ifdef DYN_BANK_DRAIN_TIMEOUT_EN
        step(15);
        chk("to_last_rdy",   rdy,   1'b0);
        chk("to_last_abort", abort, 1'b0);
        step(1);
        chk("to_abort_rdy",   rdy,   1'b1);
        chk("to_abort_pulse", abort, 1'b1);
        chk("to_abort_grant", grant, 5'b00100);
        step(1);
        chk("to_abort_clr", abort, 1'b0);
        chk("to_hold_rdy1", rdy,   1'b1);
        step(3);
        chk("to_hold_rdy4", rdy, 1'b1);
        step(1);
        chk("to_redrain_rdy", rdy, 1'b0);
`else
        step(16);
        chk("nd_drain_rdy",   rdy,   1'b0);
        chk("nd_drain_abort", abort, 1'b0);
        step(20);
        chk("nd_long_rdy",   rdy,   1'b0);
        chk("nd_long_abort", abort, 1'b0);
        chk("nd_long_grant", grant, 5'b00100);
`endif

        // Reset asserted during the SWITCH cycle.
        do_reset();
        drive(5'b00001, 1'b0, 2'b11);
        step(18);
        chk("sw_state_rdy", rdy, 1'b0);
        reset = 1'b1;
        #1;
        chk("sw_rst_grant", grant, 5'b00100);
        chk("sw_rst_rdy",   rdy,   1'b1);
        chk("sw_rst_gc",    gc,    1'b0);
        step(1);
        chk("sw_rst_gc2",    gc,    1'b0);
        chk("sw_rst_grant2", grant, 5'b00100);
        reset = 1'b0;
        drive(5'b00000, 1'b0, 2'b11);
        step(1);
        chk("sw_post_gc",    gc,    1'b0);
        chk("sw_post_grant", grant, 5'b00100);
        chk("sw_post_rdy",   rdy,   1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
